// File: rtl/plab4_net_domain_demux_pkg.sv
// Shared definitions for the two-domain link demux: net-message width macros,
// the domain-tag bit position, domain enum and counter constants.
`ifndef VC_NET_MSG_NBITS
`define VC_NET_MSG_NBITS(p_, o_, s_) ((p_) + (o_) + 2 * (s_))
`endif

`ifndef PLAB4_NET_DOMAIN_TAG_BIT
`define PLAB4_NET_DOMAIN_TAG_BIT(p_, o_, s_) `VC_NET_MSG_NBITS(p_, o_, s_)
`endif

package plab4_net_domain_demux_pkg;

  typedef enum logic {
    DOM_D0 = 1'b0,
    DOM_D1 = 1'b1
  } dom_e;

  localparam int unsigned CNT_NBITS = 8;
  localparam logic [CNT_NBITS-1:0] CNT_MAX = '1;

  // A depth-1 buffer still needs a 1-bit pointer to keep the index legal.
  function automatic int unsigned ptr_nbits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/plab4_net_domain_demux_buf.sv
// Per-domain FIFO with occupancy output. PLAB4_NET_DOMAIN_DEMUX_BYPASS_EN adds
// a combinational pass-through when the buffer is empty.
module plab4_net_DomainDemuxBuf
  import plab4_net_domain_demux_pkg::*;
#(
  parameter  int unsigned p_msg_nbits = 41,
  parameter  int unsigned p_num_msgs  = 2,
  localparam int unsigned c_occ_nbits = $clog2(p_num_msgs + 1)
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg,
  output logic [c_occ_nbits-1:0] occ
);

  localparam int unsigned c_ptr_nbits = ptr_nbits(p_num_msgs);
  localparam logic [c_ptr_nbits-1:0] c_last_ptr = c_ptr_nbits'(p_num_msgs - 1);
  localparam logic [c_occ_nbits-1:0] c_full_occ = c_occ_nbits'(p_num_msgs);

  logic [p_msg_nbits-1:0] mem_q [p_num_msgs];
  logic [p_msg_nbits-1:0] mem_d [p_num_msgs];
  logic [c_ptr_nbits-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_ptr_nbits-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_occ_nbits-1:0] occ_q, occ_d;

  logic empty;
  logic bypass;
  logic do_enq;
  logic do_deq;

  function automatic logic [c_ptr_nbits-1:0] ptr_inc(input logic [c_ptr_nbits-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty   = (occ_q == '0);
    // Acceptance looks only at occupancy: a full buffer never takes a message
    // even if its head leaves in the same cycle.
    enq_rdy = (occ_q < c_full_occ);
`ifdef PLAB4_NET_DOMAIN_DEMUX_BYPASS_EN
    bypass  = empty && enq_val && deq_rdy;
    deq_val = !empty || enq_val;
    deq_msg = empty ? enq_msg : mem_q[rd_ptr_q];
`else
    bypass  = 1'b0;
    deq_val = !empty;
    deq_msg = mem_q[rd_ptr_q];
`endif
    do_enq  = enq_val && enq_rdy && !bypass;
    do_deq  = !empty && deq_rdy;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_enq) begin
      mem_d[wr_ptr_q] = enq_msg;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_deq) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_enq, do_deq})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < p_num_msgs; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ = occ_q;

endmodule

// File: rtl/plab4_net_domain_demux.sv
// Splits one domain-tagged link into two untagged per-domain val/rdy streams
// with independent buffers and saturating delivery counters.
// Optional: PLAB4_NET_DOMAIN_DEMUX_BYPASS_EN enables empty-buffer pass-through.
module plab4_net_domain_demux
  import plab4_net_domain_demux_pkg::*;
#(
  parameter  int unsigned p_payload_nbits = 32,
  parameter  int unsigned p_opaque_nbits  = 3,
  parameter  int unsigned p_srcdest_nbits = 3,
  parameter  int unsigned p_num_msgs      = 2,
  localparam int unsigned c_net_msg_nbits =
    `VC_NET_MSG_NBITS(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits),
  localparam int unsigned c_occ_nbits     = $clog2(p_num_msgs + 1)
)(
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [c_net_msg_nbits:0]   in_msg,

  output logic                       out_val_d0,
  input  logic                       out_rdy_d0,
  output logic [c_net_msg_nbits-1:0] out_msg_d0,

  output logic                       out_val_d1,
  input  logic                       out_rdy_d1,
  output logic [c_net_msg_nbits-1:0] out_msg_d1,

  output logic [CNT_NBITS-1:0]       count_d0,
  output logic [CNT_NBITS-1:0]       count_d1,
  output logic [c_occ_nbits-1:0]     occ_d0,
  output logic [c_occ_nbits-1:0]     occ_d1
);

  localparam int unsigned c_tag_bit =
    `PLAB4_NET_DOMAIN_TAG_BIT(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits);

  dom_e                       tag;
  logic [c_net_msg_nbits-1:0] msg;
  logic                       enq_val_d0, enq_val_d1;
  logic                       enq_rdy_d0, enq_rdy_d1;
  logic                       fire_d0, fire_d1;

  logic [CNT_NBITS-1:0] count_d0_q, count_d0_d;
  logic [CNT_NBITS-1:0] count_d1_q, count_d1_d;

  always_comb begin
    tag        = dom_e'(in_msg[c_tag_bit]);
    msg        = in_msg[c_net_msg_nbits-1:0];
    enq_val_d0 = in_val && (tag == DOM_D0);
    enq_val_d1 = in_val && (tag == DOM_D1);
    in_rdy     = (tag == DOM_D1) ? enq_rdy_d1 : enq_rdy_d0;
  end

  plab4_net_DomainDemuxBuf #(
    .p_msg_nbits (c_net_msg_nbits),
    .p_num_msgs  (p_num_msgs)
  ) buf_d0 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq_val_d0),
    .enq_rdy (enq_rdy_d0),
    .enq_msg (msg),
    .deq_val (out_val_d0),
    .deq_rdy (out_rdy_d0),
    .deq_msg (out_msg_d0),
    .occ     (occ_d0)
  );

  plab4_net_DomainDemuxBuf #(
    .p_msg_nbits (c_net_msg_nbits),
    .p_num_msgs  (p_num_msgs)
  ) buf_d1 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq_val_d1),
    .enq_rdy (enq_rdy_d1),
    .enq_msg (msg),
    .deq_val (out_val_d1),
    .deq_rdy (out_rdy_d1),
    .deq_msg (out_msg_d1),
    .occ     (occ_d1)
  );

  always_comb begin
    fire_d0    = out_val_d0 && out_rdy_d0;
    fire_d1    = out_val_d1 && out_rdy_d1;
    count_d0_d = count_d0_q;
    count_d1_d = count_d1_q;
    if (fire_d0 && (count_d0_q != CNT_MAX)) begin
      count_d0_d = count_d0_q + 1'b1;
    end
    if (fire_d1 && (count_d1_q != CNT_MAX)) begin
      count_d1_d = count_d1_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_d0_q <= '0;
      count_d1_q <= '0;
    end else begin
      count_d0_q <= count_d0_d;
      count_d1_q <= count_d1_d;
    end
  end

  assign count_d0 = count_d0_q;
  assign count_d1 = count_d1_q;

endmodule

// File: tb/tb_plab4_net_domain_demux.sv
// Scoreboard bench for plab4_net_domain_demux: a per-domain queue model of
// accepted messages is checked by an independent negedge monitor.
module tb_plab4_net_domain_demux;

  localparam int unsigned MW    = 41;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_val;
  logic          in_rdy;
  logic [MW:0]   in_msg;
  logic          out_val_d0, out_rdy_d0, out_val_d1, out_rdy_d1;
  logic [MW-1:0] out_msg_d0, out_msg_d1;
  logic [7:0]    count_d0, count_d1;
  logic [1:0]    occ_d0, occ_d1;

  always #5 clk = ~clk;

  plab4_net_domain_demux #(
    .p_payload_nbits (32),
    .p_opaque_nbits  (3),
    .p_srcdest_nbits (3),
    .p_num_msgs      (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_msg     (in_msg),
    .out_val_d0 (out_val_d0),
    .out_rdy_d0 (out_rdy_d0),
    .out_msg_d0 (out_msg_d0),
    .out_val_d1 (out_val_d1),
    .out_rdy_d1 (out_rdy_d1),
    .out_msg_d1 (out_msg_d1),
    .count_d0   (count_d0),
    .count_d1   (count_d1),
    .occ_d0     (occ_d0),
    .occ_d1     (occ_d1)
  );

  // Reference model: messages accepted but not yet delivered, per domain.
  logic [MW-1:0] exp_q [2][$];
  int unsigned   delivered [2];
  int            compared   = 0;
  int            mismatched = 0;
  bit            mon_en     = 1'b0;
  bit            pend_val   = 1'b0;
  bit            pend_tag   = 1'b0;
  logic [MW-1:0] pend_msg   = '0;
  bit            byp_now [2];

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One link cycle: commit last cycle's acceptance, then drive new inputs.
  task automatic cycle(input bit v, input bit t, input logic [MW-1:0] p,
                       input bit r0, input bit r1);
    @(posedge clk);
    #1;
    if (pend_val) exp_q[pend_tag].push_back(pend_msg);
    pend_val   = 1'b0;
    byp_now[0] = 1'b0;
    byp_now[1] = 1'b0;
    in_val     = v;
    in_msg     = {t, p};
    out_rdy_d0 = r0;
    out_rdy_d1 = r1;
    if (v && (exp_q[t].size() < DEPTH)) begin
`ifdef PLAB4_NET_DOMAIN_DEMUX_BYPASS_EN
      if (exp_q[t].size() == 0 && (t ? r1 : r0)) begin
        exp_q[t].push_back(p);
        byp_now[t] = 1'b1;
      end else begin
        pend_val = 1'b1; pend_tag = t; pend_msg = p;
      end
`else
      pend_val = 1'b1; pend_tag = t; pend_msg = p;
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    #2;
    mon_en     = 1'b0;
    reset      = 1'b0;
    in_val     = 1'b0;
    out_rdy_d0 = 1'b0;
    out_rdy_d1 = 1'b0;
    #1;
    if (check) begin
      chk("rst_out_val_d0", longint'(out_val_d0), 0);
      chk("rst_out_val_d1", longint'(out_val_d1), 0);
      chk("rst_occ_d0",     longint'(occ_d0), 0);
      chk("rst_occ_d1",     longint'(occ_d1), 0);
      chk("rst_count_d0",   longint'(count_d0), 0);
      chk("rst_count_d1",   longint'(count_d1), 0);
      chk("rst_in_rdy",     longint'(in_rdy), 1);
    end
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      delivered[d] = 0;
      byp_now[d]   = 1'b0;
    end
    pend_val = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: checks handshake/status against the model and scores deliveries.
  always @(negedge clk) begin : monitor
    bit            t;
    int            sz  [2];
    bit            ov  [2];
    bit            orr [2];
    bit            eov;
    logic [MW-1:0] om  [2];
    logic [MW-1:0] want;
    if (mon_en) begin
      t      = in_msg[MW];
      ov[0]  = out_val_d0; ov[1]  = out_val_d1;
      orr[0] = out_rdy_d0; orr[1] = out_rdy_d1;
      om[0]  = out_msg_d0; om[1]  = out_msg_d1;
      for (int d = 0; d < 2; d++) sz[d] = exp_q[d].size() - (byp_now[d] ? 1 : 0);
      chk("in_rdy", longint'(in_rdy), longint'(sz[t] < DEPTH));
      chk("occ_d0", longint'(occ_d0), longint'(sz[0]));
      chk("occ_d1", longint'(occ_d1), longint'(sz[1]));
      chk("count_d0", longint'(count_d0), longint'(delivered[0] > 255 ? 255 : delivered[0]));
      chk("count_d1", longint'(count_d1), longint'(delivered[1] > 255 ? 255 : delivered[1]));
      for (int d = 0; d < 2; d++) begin
        eov = (exp_q[d].size() != 0);
`ifdef PLAB4_NET_DOMAIN_DEMUX_BYPASS_EN
        if (sz[d] == 0 && in_val && (int'(t) == d)) eov = 1'b1;
`endif
        chk($sformatf("out_val_d%0d", d), longint'(ov[d]), longint'(eov));
        if (ov[d] && orr[d]) begin
          if (exp_q[d].size() == 0) begin
            chk($sformatf("unexpected_d%0d", d), 1, 0);
          end else begin
            want = exp_q[d].pop_front();
            chk($sformatf("out_msg_d%0d", d), longint'(om[d]), longint'(want));
          end
          delivered[d]++;
        end
      end
    end
  end

  initial begin
    logic [MW-1:0] p;
    reset      = 1'b0;
    in_val     = 1'b0;
    in_msg     = '0;
    out_rdy_d0 = 1'b0;
    out_rdy_d1 = 1'b0;
    byp_now[0] = 1'b0;
    byp_now[1] = 1'b0;
    #12;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Park one message in each buffer, then reset asynchronously mid-stream.
    cycle(1'b1, 1'b0, 41'h11, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 41'h22, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0,     1'b0, 1'b0);
    do_reset(1'b1);

    // Interleave across domains with both outputs ready.
    cycle(1'b1, 1'b0, 41'hA, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 41'hB, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 41'hC, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 41'hD, 1'b1, 1'b1);
    idle(3);
    @(negedge clk); #1;
    chk("interleave_count_d0", longint'(count_d0), 2);
    chk("interleave_count_d1", longint'(count_d1), 2);

    // Isolation: stalled d0 blocks only tag-0 traffic.
    cycle(1'b1, 1'b0, 41'h101, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 41'h102, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 41'h103, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("iso_in_rdy_blocked", longint'(in_rdy), 0);
    cycle(1'b1, 1'b1, 41'h104, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("iso_in_rdy_d1", longint'(in_rdy), 1);
    cycle(1'b1, 1'b0, 41'h103, 1'b1, 1'b1);
    idle(4);

    // Full d1 with its output firing: no ready-through.
    cycle(1'b1, 1'b1, 41'h201, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 41'h202, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 41'h203, 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("full_in_rdy", longint'(in_rdy), 0);
    cycle(1'b1, 1'b1, 41'h203, 1'b1, 1'b0);
    @(negedge clk); #1;
    chk("full_next_in_rdy", longint'(in_rdy), 1);
    idle(4);

    // Saturation: 300 d0 deliveries from a clean state.
    do_reset(1'b0);
    for (int i = 0; i < 300; i++) begin
      p = MW'({$urandom, $urandom});
      cycle(1'b1, 1'b0, p, 1'b1, 1'b0);
    end
    idle(3);
    @(negedge clk); #1;
    chk("sat_count_d0", longint'(count_d0), 255);
    chk("sat_count_d1", longint'(count_d1), 0);

    // Randomised traffic.
    do_reset(1'b0);
    for (int i = 0; i < 2000; i++) begin
      p = MW'({$urandom, $urandom});
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, p,
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
    end
    idle(5);
    @(negedge clk); #1;
    chk("final_occ_d0", longint'(occ_d0), 0);
    chk("final_occ_d1", longint'(occ_d1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
